// File: rtl/wb_port_arbiter_if.sv
// Result-source to write-back-port bundle between execute-stage FUs and the scoreboard.
// Latency: none of its own (wires only); write-back fields are registered by the arbiter.
// Backpressure: req_ready_o is the only back-signal; write-back ports are never stalled.
interface wb_port_arbiter_if #(
  parameter int NR_REQ        = 6,
  parameter int NR_WB_PORTS   = 4,
  parameter int TRANS_ID_BITS = 3,
  parameter int XLEN          = 64
);

  // requester side
  logic                                        flush_i;
  logic [NR_REQ-1:0]                           req_valid_i;
  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]        req_trans_id_i;
  logic [NR_REQ-1:0][XLEN-1:0]                 req_data_i;
  logic [NR_REQ-1:0]                           req_ex_valid_i;
  logic [NR_REQ-1:0][XLEN-1:0]                 req_ex_cause_i;
  logic [NR_REQ-1:0]                           req_ready_o;

  // scoreboard write-back side
  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   trans_id_o;
  logic [NR_WB_PORTS-1:0][XLEN-1:0]            wbdata_o;
  logic [NR_WB_PORTS-1:0]                      ex_valid_o;
  logic [NR_WB_PORTS-1:0][XLEN-1:0]            ex_cause_o;
  logic [NR_WB_PORTS-1:0]                      wt_valid_o;
  logic [15:0]                                 stall_cnt_o;

  // FU results / scoreboard consumer side
  modport master (
    output flush_i, req_valid_i, req_trans_id_i, req_data_i, req_ex_valid_i, req_ex_cause_i,
    input  req_ready_o, trans_id_o, wbdata_o, ex_valid_o, ex_cause_o, wt_valid_o, stall_cnt_o
  );

  // arbiter side
  modport slave (
    input  flush_i, req_valid_i, req_trans_id_i, req_data_i, req_ex_valid_i, req_ex_cause_i,
    output req_ready_o, trans_id_o, wbdata_o, ex_valid_o, ex_cause_o, wt_valid_o, stall_cnt_o
  );

endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin share of NR_WB_PORTS write-back ports among NR_REQ FU result sources.
// Latency: grant (req_ready_o, combinational) in cycle N, registered write-back in cycle N+1.
// Backpressure: ungranted requesters hold until ready; write-back ports are never stalled.
module wb_port_arbiter #(
  parameter int NR_REQ        = 6,
  parameter int NR_WB_PORTS   = 4,
  parameter int TRANS_ID_BITS = 3,
  parameter int XLEN          = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  wb_port_arbiter_if.slave      bus
);

  localparam int PW = $clog2(NR_REQ);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          data;
    logic                     ex_valid;
    logic [XLEN-1:0]          ex_cause;
    logic                     wt_valid;
  } wb_port_t;

  logic [PW-1:0]                      rr_q, rr_d;
  logic [PW-1:0]                      last_idx;
  logic [NR_REQ-1:0]                  eligible;
  logic [NR_REQ-1:0]                  gnt;
  logic [NR_WB_PORTS-1:0]             port_vld;
  logic [NR_WB_PORTS-1:0][PW-1:0]     port_sel;
  logic                               contend;
  logic [15:0]                        stall_cnt_q;
  wb_port_t [NR_WB_PORTS-1:0]         port_q;

  // Position k of the scan starting at base, wrapped for any NR_REQ (not only powers of two).
  function automatic logic [PW-1:0] scan_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NR_REQ) s = s - NR_REQ;
    return s[PW-1:0];
  endfunction

  // Nothing may be granted during reset or in a flush cycle.
  assign eligible = (rst_ni && !bus.flush_i) ? bus.req_valid_i : '0;

  // Scan from rr_q, granting the first NR_WB_PORTS valid requesters; the k-th grant drives port k.
  always_comb begin : scan
    int            n_gnt;
    logic [PW-1:0] idx;
    gnt      = '0;
    port_vld = '0;
    port_sel = '0;
    last_idx = rr_q;
    n_gnt    = 0;
    idx      = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      idx = scan_idx(rr_q, k);
      if (eligible[idx] && (n_gnt < NR_WB_PORTS)) begin
        gnt[idx] = 1'b1;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
          if (p == n_gnt) begin
            port_sel[p] = idx;
            port_vld[p] = 1'b1;
          end
        end
        last_idx = idx;
        n_gnt++;
      end
    end
  end

  assign bus.req_ready_o = gnt;

  // Next pointer: one past the last grant, zero on flush, unchanged when idle.
  always_comb begin
    rr_d = rr_q;
    if (bus.flush_i) begin
      rr_d = '0;
    end else if (|gnt) begin
      rr_d = (last_idx == PW'(NR_REQ - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  // Contention means more valid requesters than ports; a flush cycle never counts.
  always_comb begin : count_valid
    int n_valid;
    n_valid = 0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (bus.req_valid_i[i]) n_valid++;
    end
    contend = !bus.flush_i && (n_valid > NR_WB_PORTS);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

  // Saturating contention counter; flush deliberately leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (contend && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Write-back port registers: payload loads only on grant, valids clear otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      port_q <= '0;
    end else begin
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (port_vld[p]) begin
          port_q[p].trans_id <= bus.req_trans_id_i[port_sel[p]];
          port_q[p].data     <= bus.req_data_i[port_sel[p]];
          port_q[p].ex_valid <= bus.req_ex_valid_i[port_sel[p]];
          port_q[p].ex_cause <= bus.req_ex_cause_i[port_sel[p]];
          port_q[p].wt_valid <= 1'b1;
        end else begin
          port_q[p].ex_valid <= 1'b0;
          port_q[p].wt_valid <= 1'b0;
        end
      end
    end
  end

  // Unpack the port registers onto the scoreboard-facing fields.
  always_comb begin
    bus.trans_id_o = '0;
    bus.wbdata_o   = '0;
    bus.ex_valid_o = '0;
    bus.ex_cause_o = '0;
    bus.wt_valid_o = '0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      bus.trans_id_o[p] = port_q[p].trans_id;
      bus.wbdata_o[p]   = port_q[p].data;
      bus.ex_valid_o[p] = port_q[p].ex_valid;
      bus.ex_cause_o[p] = port_q[p].ex_cause;
      bus.wt_valid_o[p] = port_q[p].wt_valid;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with NR_REQ=4, NR_WB_PORTS=2.
// Latency: grants sampled at the falling edge, write-back ports 1 time unit after the rising edge.
// Backpressure: requesters hold valid/payload until granted, as the arbiter expects.
module tb_wb_port_arbiter;

  localparam int NR_REQ = 4;
  localparam int NR_WB  = 2;
  localparam int TIDW   = 3;
  localparam int XLEN   = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  wb_port_arbiter_if #(.NR_REQ(NR_REQ), .NR_WB_PORTS(NR_WB), .TRANS_ID_BITS(TIDW), .XLEN(XLEN)) bus ();

  wb_port_arbiter #(.NR_REQ(NR_REQ), .NR_WB_PORTS(NR_WB), .TRANS_ID_BITS(TIDW), .XLEN(XLEN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [3:0]  exp_gnt [4];
    logic [31:0] exp_d0  [4];
    logic [31:0] exp_d1  [4];
    logic [1:0]  exp_rr  [4];
    checks = 0;
    errors = 0;
    exp_gnt = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    exp_d0  = '{32'h100, 32'h102, 32'h100, 32'h102};
    exp_d1  = '{32'h101, 32'h103, 32'h101, 32'h103};
    exp_rr  = '{2'd2, 2'd0, 2'd2, 2'd0};

    // default payload: tag i, data 0x100+i, no exceptions
    bus.flush_i = 1'b0;
    for (int i = 0; i < NR_REQ; i++) begin
      bus.req_trans_id_i[i] = TIDW'(i);
      bus.req_data_i[i]     = 32'h100 + 32'(i);
      bus.req_ex_valid_i[i] = 1'b0;
      bus.req_ex_cause_i[i] = '0;
    end

    // reset with requests pending: nothing may be granted
    rst_n = 1'b0;
    bus.req_valid_i = 4'b1111;
    #3;
    check("rst_ready", bus.req_ready_o, 4'b0000);
    check("rst_wt_valid", bus.wt_valid_o, 2'b00);
    check("rst_ex_valid", bus.ex_valid_o, 2'b00);
    check("rst_wbdata", bus.wbdata_o, 64'h0);
    check("rst_trans_id", bus.trans_id_o, 6'h0);
    check("rst_ex_cause", bus.ex_cause_o, 64'h0);
    check("rst_stall", bus.stall_cnt_o, 16'h0);
    bus.req_valid_i = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // idle for 10 cycles
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_ready", bus.req_ready_o, 4'b0000);
      check("idle_wt_valid", bus.wt_valid_o, 2'b00);
    end
    check("idle_stall", bus.stall_cnt_o, 16'h0);

    // single requester 2 lands on port 0
    bus.req_trans_id_i[2] = 3'd3;
    bus.req_data_i[2]     = 32'hAB;
    bus.req_valid_i       = 4'b0100;
    @(negedge clk);
    check("single_ready", bus.req_ready_o, 4'b0100);
    tick();
    bus.req_valid_i = 4'b0000;
    check("single_wt_valid", bus.wt_valid_o, 2'b01);
    check("single_tid", bus.trans_id_o[0], 3'd3);
    check("single_data", bus.wbdata_o[0], 32'hAB);
    check("single_rr", dut.rr_q, 2'd3);
    bus.req_trans_id_i[2] = 3'd2;
    bus.req_data_i[2]     = 32'h102;

    // exception on req 3 with rr_q=3: scan 3,0 puts req 3 on port 0, req 0 on port 1
    bus.req_ex_valid_i[3] = 1'b1;
    bus.req_ex_cause_i[3] = 32'd2;
    bus.req_valid_i       = 4'b1001;
    @(negedge clk);
    check("ex_ready", bus.req_ready_o, 4'b1001);
    tick();
    check("ex_wt_valid", bus.wt_valid_o, 2'b11);
    check("ex_valid", bus.ex_valid_o, 2'b01);
    check("ex_cause0", bus.ex_cause_o[0], 32'd2);
    check("ex_tid0", bus.trans_id_o[0], 3'd3);
    check("ex_data1", bus.wbdata_o[1], 32'h100);
    check("ex_rr", dut.rr_q, 2'd1);
    bus.req_ex_valid_i[3] = 1'b0;
    bus.req_ex_cause_i[3] = '0;

    // flush with all valid: no grants, ports cleared, pointer to 0, no stall count
    bus.flush_i     = 1'b1;
    bus.req_valid_i = 4'b1111;
    @(negedge clk);
    check("flush_ready", bus.req_ready_o, 4'b0000);
    tick();
    bus.flush_i = 1'b0;
    check("flush_wt_valid", bus.wt_valid_o, 2'b00);
    check("flush_ex_valid", bus.ex_valid_o, 2'b00);
    check("flush_rr", dut.rr_q, 2'd0);
    check("flush_stall", bus.stall_cnt_o, 16'h0);

    // all four valid for four cycles from rr_q=0
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rr4_ready", bus.req_ready_o, exp_gnt[c]);
      tick();
      check("rr4_data0", bus.wbdata_o[0], exp_d0[c]);
      check("rr4_data1", bus.wbdata_o[1], exp_d1[c]);
      check("rr4_rr", dut.rr_q, exp_rr[c]);
    end
    check("rr4_stall", bus.stall_cnt_o, 16'd4);

    // move pointer to 2, then wrap: req 2 takes port 0 ahead of req 0
    bus.req_valid_i = 4'b0011;
    tick();
    check("wrap_pre_rr", dut.rr_q, 2'd2);
    bus.req_valid_i = 4'b0101;
    @(negedge clk);
    check("wrap_ready", bus.req_ready_o, 4'b0101);
    tick();
    check("wrap_data0", bus.wbdata_o[0], 32'h102);
    check("wrap_data1", bus.wbdata_o[1], 32'h100);
    check("wrap_rr", dut.rr_q, 2'd1);
    check("wrap_stall", bus.stall_cnt_o, 16'd4);

    // asynchronous reset mid-cycle clears registered outputs at once
    tick();
    check("arst_pre_wt", bus.wt_valid_o, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wt_valid", bus.wt_valid_o, 2'b00);
    check("arst_wbdata", bus.wbdata_o, 64'h0);
    check("arst_stall", bus.stall_cnt_o, 16'h0);
    check("arst_ready", bus.req_ready_o, 4'b0000);
    check("arst_rr", dut.rr_q, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // saturation: 65540 contention cycles
    bus.req_valid_i = 4'b1111;
    repeat (65540) @(posedge clk);
    #1;
    check("sat_stall", bus.stall_cnt_o, 16'hFFFF);
    tick();
    check("sat_hold", bus.stall_cnt_o, 16'hFFFF);
    bus.req_valid_i = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
